// File: rtl/burst_reader.sv
// Burst read master: requests the bus, issues one begin cycle, then collects responder words.
// Optional receive-idle timeout enabled by defining BURST_READER_TIMEOUT_EN.
module burst_reader (
  input  logic        clock,
  input  logic        reset,
  input  logic        startIn,
  input  logic [31:0] addressIn,
  input  logic [7:0]  burstSizeIn,
  output logic        busyOut,
  output logic [31:0] dataOut,
  output logic        dataValidOut,
  output logic        doneOut,
  output logic        errorOut,
  output logic        busRequestOut,
  input  logic        busGrantIn,
  output logic [31:0] addressDataOut,
  output logic        beginTransactionOut,
  output logic        readNotWriteOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        endTransactionOut,
  input  logic [31:0] addressDataIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQUEST   = 3'd1,
    S_BEGIN     = 3'd2,
    S_RECEIVE   = 3'd3,
    S_TERMINATE = 3'd4,
    S_FINISH    = 3'd5
  } state_t;

  state_t      state_r;
  state_t      nextState_s;
  logic [31:0] addr_r;
  logic [7:0]  burstSize_r;
  logic [8:0]  wordCount_r;
  logic [8:0]  wordCountNext_s;
  logic [8:0]  burstWords_s;
  logic        acceptWord_s;
  logic        complete_s;
  logic        beginNext_s;
`ifdef BURST_READER_TIMEOUT_EN
  logic [7:0]  idleCount_r;
`endif

  assign burstWords_s    = {1'b0, burstSize_r} + 9'd1;
  assign wordCountNext_s = acceptWord_s ? (wordCount_r + 9'd1) : wordCount_r;
  assign complete_s      = (wordCountNext_s == burstWords_s);
  assign beginNext_s     = (nextState_s == S_BEGIN);

  // Next-state logic; a bus error wins over end, and an end still takes a same-cycle word.
  always_comb begin
    nextState_s  = state_r;
    acceptWord_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (startIn) nextState_s = S_REQUEST;
        else         nextState_s = S_IDLE;
      end
      S_REQUEST: begin
        if (busGrantIn) nextState_s = S_BEGIN;
        else            nextState_s = S_REQUEST;
      end
      S_BEGIN: nextState_s = S_RECEIVE;
      S_RECEIVE: begin
        if (busErrorIn) begin
          nextState_s = S_TERMINATE;
        end else begin
          acceptWord_s = dataValidIn && (wordCount_r < burstWords_s);
          if (endTransactionIn) begin
            nextState_s = S_FINISH;
`ifdef BURST_READER_TIMEOUT_EN
          end else if (!dataValidIn && (idleCount_r == 8'd254)) begin
            nextState_s = S_TERMINATE;
`endif
          end else begin
            nextState_s = S_RECEIVE;
          end
        end
      end
      S_TERMINATE: nextState_s = S_IDLE;
      S_FINISH:    nextState_s = S_IDLE;
      default:     nextState_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= nextState_s;
  end

  // Request latches, word counter and all registered outputs (decoded from the next state).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_r              <= 32'd0;
      burstSize_r         <= 8'd0;
      wordCount_r         <= 9'd0;
      busyOut             <= 1'b0;
      dataOut             <= 32'd0;
      dataValidOut        <= 1'b0;
      doneOut             <= 1'b0;
      errorOut            <= 1'b0;
      busRequestOut       <= 1'b0;
      addressDataOut      <= 32'd0;
      beginTransactionOut <= 1'b0;
      readNotWriteOut     <= 1'b0;
      byteEnablesOut      <= 4'h0;
      burstSizeOut        <= 8'd0;
      endTransactionOut   <= 1'b0;
    end else begin
      if ((state_r == S_IDLE) && startIn) begin
        addr_r      <= addressIn;
        burstSize_r <= burstSizeIn;
      end
      wordCount_r <= (state_r == S_IDLE) ? 9'd0 : wordCountNext_s;
      if (acceptWord_s) dataOut <= addressDataIn;
      dataValidOut        <= acceptWord_s;
      busyOut             <= (nextState_s != S_IDLE);
      busRequestOut       <= (nextState_s == S_REQUEST) || (nextState_s == S_BEGIN) ||
                             (nextState_s == S_RECEIVE) || (nextState_s == S_TERMINATE);
      doneOut             <= (nextState_s == S_FINISH) && complete_s;
      errorOut            <= (nextState_s == S_TERMINATE) ||
                             ((nextState_s == S_FINISH) && !complete_s);
      endTransactionOut   <= (nextState_s == S_TERMINATE);
      beginTransactionOut <= beginNext_s;
      readNotWriteOut     <= beginNext_s;
      addressDataOut      <= beginNext_s ? addr_r : 32'd0;
      byteEnablesOut      <= beginNext_s ? 4'hF : 4'h0;
      burstSizeOut        <= beginNext_s ? burstSize_r : 8'd0;
    end
  end

`ifdef BURST_READER_TIMEOUT_EN
  // Receive idle counter; the cycle it would reach 255 the FSM heads to TERMINATE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) idleCount_r <= 8'd0;
    else       idleCount_r <= ((state_r == S_RECEIVE) && !dataValidIn) ? (idleCount_r + 8'd1) : 8'd0;
  end
`endif

endmodule

// File: tb/tb_burst_reader.sv
// Directed, table-driven bench for burst_reader, plus hand-written multi-cycle corner cases.
module tb_burst_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        startIn;
  logic [31:0] addressIn;
  logic [7:0]  burstSizeIn;
  logic        busyOut;
  logic [31:0] dataOut;
  logic        dataValidOut;
  logic        doneOut;
  logic        errorOut;
  logic        busRequestOut;
  logic        busGrantIn;
  logic [31:0] addressDataOut;
  logic        beginTransactionOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        endTransactionOut;
  logic [31:0] addressDataIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;

  int checks = 0;
  int errors = 0;

  burst_reader dut (
    .clock(clock), .reset(reset), .startIn(startIn), .addressIn(addressIn),
    .burstSizeIn(burstSizeIn), .busyOut(busyOut), .dataOut(dataOut),
    .dataValidOut(dataValidOut), .doneOut(doneOut), .errorOut(errorOut),
    .busRequestOut(busRequestOut), .busGrantIn(busGrantIn),
    .addressDataOut(addressDataOut), .beginTransactionOut(beginTransactionOut),
    .readNotWriteOut(readNotWriteOut), .byteEnablesOut(byteEnablesOut),
    .burstSizeOut(burstSizeOut), .endTransactionOut(endTransactionOut),
    .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn)
  );

  always #5 clock = ~clock;

  // control bits: busy, busRequest, begin, readNotWrite, dataValid, done, error, endTransaction
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_REQ   = 8'b1100_0000;
  localparam logic [7:0] C_BEG   = 8'b1111_0000;
  localparam logic [7:0] C_RX    = 8'b1100_0000;
  localparam logic [7:0] C_RXV   = 8'b1100_1000;
  localparam logic [7:0] C_OK    = 8'b1000_0100;
  localparam logic [7:0] C_OKV   = 8'b1000_1100;
  localparam logic [7:0] C_SHORT = 8'b1000_0010;
  localparam logic [7:0] C_TERM  = 8'b1100_0011;

  typedef struct {
    logic        start, grant, dv, endIn, err;
    logic [31:0] din, addr;
    logic [7:0]  size;
    logic [7:0]  ctl;
    logic [31:0] dout;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] tAddr;
  logic [7:0]  tSize;

  function automatic logic [7:0] ctlNow();
    return {busyOut, busRequestOut, beginTransactionOut, readNotWriteOut,
            dataValidOut, doneOut, errorOut, endTransactionOut};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addV(input logic s, g, d, e, b, input logic [31:0] din,
                      input logic [7:0] ctl, input logic [31:0] dout);
    vec_t v;
    v.start = s; v.grant = g; v.dv = d; v.endIn = e; v.err = b; v.din = din;
    v.addr = tAddr; v.size = tSize; v.ctl = ctl; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic idleInputs();
    startIn = 1'b0; busGrantIn = 1'b0; dataValidIn = 1'b0;
    endTransactionIn = 1'b0; busErrorIn = 1'b0; addressDataIn = 32'd0;
  endtask

  task automatic startTo(input logic [31:0] a, input logic [7:0] s);
    addressIn = a; burstSizeIn = s; startIn = 1'b1; busGrantIn = 1'b1;
    tick(); startIn = 1'b0;
    tick(); busGrantIn = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int begins;
    int cnt;
    logic flag;
    logic bad;

    idleInputs();
    addressIn = 32'd0; burstSizeIn = 8'd0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset outputs", {ctlNow(), dataOut, byteEnablesOut, burstSizeOut, addressDataOut}, 128'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    tick();

    // 4-word burst at 0xF0000000, clean completion
    tAddr = 32'hF000_0000; tSize = 8'd3;
    addV(1'b1,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_REQ,  32'd0);
    addV(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_BEG,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_RX,   32'd0);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'hA000_0000, C_RXV, 32'hA000_0000);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'hA000_0001, C_RXV, 32'hA000_0001);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'hA000_0002, C_RXV, 32'hA000_0002);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'hA000_0003, C_RXV, 32'hA000_0003);
    addV(1'b0,1'b0,1'b0,1'b1,1'b0, 32'd0,        C_OK,   32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_IDLE, 32'd0);
    // single word with end in the same cycle
    tAddr = 32'h0000_0100; tSize = 8'd0;
    addV(1'b1,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_REQ,  32'd0);
    addV(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_BEG,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_RX,   32'd0);
    addV(1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0000_CAFE, C_OKV, 32'h0000_CAFE);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_IDLE, 32'd0);
    // bus error after 2 of 8 words; the error-cycle word and the end are ignored
    tAddr = 32'h0000_2000; tSize = 8'd7;
    addV(1'b1,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_REQ,  32'd0);
    addV(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_BEG,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_RX,   32'd0);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_00D0, C_RXV, 32'h0000_00D0);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_00D1, C_RXV, 32'h0000_00D1);
    addV(1'b0,1'b0,1'b1,1'b1,1'b1, 32'h0000_DEAD, C_TERM, 32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_IDLE, 32'd0);
    // short burst: 2 of 4 words then end
    tAddr = 32'h0000_3000; tSize = 8'd3;
    addV(1'b1,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_REQ,  32'd0);
    addV(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_BEG,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_RX,   32'd0);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_0031, C_RXV, 32'h0000_0031);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_0032, C_RXV, 32'h0000_0032);
    addV(1'b0,1'b0,1'b0,1'b1,1'b0, 32'd0,        C_SHORT, 32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_IDLE, 32'd0);
    // extra word beyond a 1-word burst is dropped
    tAddr = 32'h0000_4000; tSize = 8'd0;
    addV(1'b1,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_REQ,  32'd0);
    addV(1'b0,1'b1,1'b0,1'b0,1'b0, 32'd0,        C_BEG,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_RX,   32'd0);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_0040, C_RXV, 32'h0000_0040);
    addV(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_0041, C_RX,  32'd0);
    addV(1'b0,1'b0,1'b0,1'b1,1'b0, 32'd0,        C_OK,   32'd0);
    addV(1'b0,1'b0,1'b0,1'b0,1'b0, 32'd0,        C_IDLE, 32'd0);

    foreach (vecs[i]) begin
      startIn = vecs[i].start; busGrantIn = vecs[i].grant; dataValidIn = vecs[i].dv;
      endTransactionIn = vecs[i].endIn; busErrorIn = vecs[i].err;
      addressDataIn = vecs[i].din; addressIn = vecs[i].addr; burstSizeIn = vecs[i].size;
      tick();
      check($sformatf("vec%0d ctl", i), ctlNow(), vecs[i].ctl);
      check($sformatf("vec%0d bus", i), {byteEnablesOut, burstSizeOut, addressDataOut},
            vecs[i].ctl[5] ? {4'hF, vecs[i].size, vecs[i].addr} : 44'd0);
      if (vecs[i].ctl[3]) check($sformatf("vec%0d data", i), dataOut, vecs[i].dout);
    end
    idleInputs();

    // grant withheld 10 cycles while start is re-issued
    addressIn = 32'h0000_5000; burstSizeIn = 8'd0; startIn = 1'b1;
    tick();
    begins = 0; flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      startIn = (i % 2 == 0); addressIn = 32'h6666_0000; burstSizeIn = 8'd9;
      tick();
      if (beginTransactionOut) begins++;
      if (!busyOut || !busRequestOut) flag = 1'b0;
    end
    check("no begin without grant", begins, 0);
    check("busy/request while waiting", flag, 1'b1);
    busGrantIn = 1'b1; startIn = 1'b1;
    tick();
    startIn = 1'b0;
    check("begin after grant", {beginTransactionOut, addressDataOut, burstSizeOut}, {1'b1, 32'h0000_5000, 8'd0});
    begins = 1;
    for (int i = 0; i < 4; i++) begin
      startIn = (i == 1);
      tick();
      if (beginTransactionOut) begins++;
    end
    check("single begin cycle", begins, 1);
    busGrantIn = 1'b0; startIn = 1'b0; endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    check("empty burst is short", {doneOut, errorOut, endTransactionOut}, 3'b010);
    tick();
    check("idle after short", {busyOut, busRequestOut}, 2'b00);

    // 256-word boundary: 257 words offered, last one dropped
    startTo(32'h0000_7000, 8'd255);
    cnt = 0; bad = 1'b0;
    for (int i = 0; i < 257; i++) begin
      dataValidIn = 1'b1; addressDataIn = i;
      tick();
      if (dataValidOut) begin
        if (dataOut !== i) bad = 1'b1;
        cnt++;
      end
    end
    dataValidIn = 1'b0; endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    check("256 words delivered", cnt, 256);
    check("256 words data in order", bad, 1'b0);
    check("256 words done", {doneOut, errorOut, dataValidOut}, 3'b100);
    tick();

    // reset in RECEIVE: outputs clear at once and no pulses follow
    startTo(32'h0000_8000, 8'd3);
    dataValidIn = 1'b1; addressDataIn = 32'h0000_1234;
    tick();
    dataValidIn = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("async reset mid-burst", {ctlNow(), dataOut, byteEnablesOut, burstSizeOut, addressDataOut}, 128'd0);
    tick();
    reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (doneOut || errorOut || endTransactionOut || busyOut) flag = 1'b1;
    end
    check("silent abort", flag, 1'b0);

    // first start after reset honoured, then receive-idle behaviour
    addressIn = 32'h0000_9000; burstSizeIn = 8'd0; startIn = 1'b1; busGrantIn = 1'b1;
    tick();
    startIn = 1'b0;
    check("start after reset", {busyOut, busRequestOut}, 2'b11);
    tick();
    busGrantIn = 1'b0;
    tick();
`ifdef BURST_READER_TIMEOUT_EN
    n = 0; flag = 1'b0;
    for (int k = 1; k <= 400 && n == 0; k++) begin
      tick();
      if (errorOut) begin
        n = k;
        flag = endTransactionOut;
      end
    end
    check("timeout latency", n, 255);
    check("timeout endTransactionOut", flag, 1'b1);
    tick();
    check("idle after timeout", {busyOut, errorOut, endTransactionOut}, 3'b000);
`else
    n = 0; flag = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (errorOut || endTransactionOut) flag = 1'b1;
    end
    check("no timeout pulse", flag, 1'b0);
    check("still waiting", {busyOut, busRequestOut}, 2'b11);
    endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
    check("late end short burst", {doneOut, errorOut, endTransactionOut}, 3'b010);
    tick();
    check("idle after late end", busyOut, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_reader.md
BURST_READER -- requirements
Module: burst_reader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
REQ-004 startIn  in  1  one-cycle read request from client; sampled only in IDLE.
REQ-005 addressIn  in  32  word-aligned start byte address; latched with startIn.
REQ-006 burstSizeIn  in  8  burst length minus one (0 = 1 word, 255 = 256 words); latched with startIn.
REQ-007 busyOut  out  1  high from the cycle after accepted startIn until the cycle doneOut or errorOut pulses.
REQ-008 dataOut  out  32  received word; valid only while dataValidOut = 1.
REQ-009 dataValidOut  out  1  one-cycle strobe per received word.
REQ-010 doneOut  out  1  one-cycle pulse on successful completion.
REQ-011 errorOut  out  1  one-cycle pulse on bus error, short burst or timeout.
REQ-012 busRequestOut  out  1  bus arbitration request.
REQ-013 busGrantIn  in  1  bus grant from arbiter.
REQ-014 addressDataOut  out  32  start address during begin cycle, else 0.
REQ-015 beginTransactionOut, readNotWriteOut  out  1 each  begin strobe and read flag; both high in the begin cycle only.
REQ-016 byteEnablesOut  out  4  4'hF in the begin cycle, else 0.
REQ-017 burstSizeOut  out  8  latched burst size in the begin cycle, else 0.
REQ-018 endTransactionOut  out  1  master-side termination strobe.
REQ-019 addressDataIn  in  32  read data from responder.
REQ-020 dataValidIn, endTransactionIn, busErrorIn  in  1 each  responder data strobe, end and error.

Function
REQ-021 SHALL implement states IDLE, REQUEST, BEGIN, RECEIVE, TERMINATE, FINISH.
REQ-022 IDLE: startIn=1 -> latch addressIn and burstSizeIn, go to REQUEST; startIn while not in IDLE is ignored.
REQ-023 REQUEST: busRequestOut=1; busGrantIn=1 -> BEGIN; otherwise wait indefinitely.
REQ-024 BEGIN: exactly one cycle; the bus begin outputs in REQ-014..017 are registered and high/valid in that cycle only; next state RECEIVE.
REQ-025 busRequestOut SHALL stay high from REQUEST through the last cycle of RECEIVE or TERMINATE.
REQ-026 RECEIVE: each cycle with dataValidIn=1 SHALL register addressDataIn to dataOut with dataValidOut=1 one cycle later and increment a 9-bit word counter.
REQ-027 Words beyond burstSizeIn+1 SHALL be dropped: no dataValidOut and no counter increment.
REQ-028 endTransactionIn=1 in RECEIVE -> FINISH; if the same cycle also has dataValidIn=1, that word SHALL be accepted first.
REQ-029 FINISH: one cycle; doneOut=1 if the word count equals burstSizeIn+1, else errorOut=1 (short burst); then IDLE.
REQ-030 busErrorIn=1 in RECEIVE -> TERMINATE; data in that cycle is discarded; busErrorIn takes priority over endTransactionIn.
REQ-031 TERMINATE: endTransactionOut=1 for exactly one cycle, errorOut=1 in the same cycle, then IDLE.
REQ-032 endTransactionOut SHALL be 0 in every state except TERMINATE.
REQ-033 Minimum latency from startIn (grant already high) to beginTransactionOut SHALL be 2 cycles.

Reset
REQ-034 On reset: state IDLE, counters 0, and every output 0 (including dataOut and addressDataOut).
REQ-035 Reset mid-transaction SHALL abort silently: no endTransactionOut and no errorOut or doneOut pulse.
REQ-036 After reset deasserts, the first startIn SHALL be honoured.

Configuration
REQ-037 With macro BURST_READER_TIMEOUT_EN defined, an 8-bit idle counter SHALL run in RECEIVE and clear on every dataValidIn.
REQ-038 With BURST_READER_TIMEOUT_EN defined, when the idle counter reaches 255 the block SHALL enter TERMINATE (endTransactionOut plus errorOut).
REQ-039 Without BURST_READER_TIMEOUT_EN, no timeout counter SHALL exist and RECEIVE SHALL wait indefinitely.

Verification
REQ-040 start addr 0xF0000000, size 3, grant high, responder sends 4 words then endTransactionIn -> 4 dataValidOut with matching data, doneOut once, endTransactionOut never asserted.
REQ-041 size 0, dataValidIn and endTransactionIn in the same cycle -> 1 word delivered, doneOut.
REQ-042 size 7, busErrorIn after 2 words -> 2 words delivered, endTransactionOut and errorOut for 1 cycle, then IDLE with busyOut=0.
REQ-043 size 3, endTransactionIn after 2 words -> errorOut, no doneOut.
REQ-044 grant withheld 10 cycles, startIn repeated while busy -> single begin cycle after grant, second start ignored.
REQ-045 Reset asserted in RECEIVE -> all outputs 0 asynchronously, no pulses; with BURST_READER_TIMEOUT_EN, a silent responder -> errorOut 255 cycles after RECEIVE entry.
